// File: rtl/memory_map.sv
// Shared address map and instruction-responder state encoding.
package memory_map;

    localparam logic [31:0] CODE_RAM_BASE_ADDRESS = 32'h0001_0000;
    localparam logic [31:0] CODE_RAM_SIZE_BYTES   = 32'h0001_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } instr_resp_state_t;

endpackage

// File: rtl/ibex_instr_bus.sv
// Ibex-style instruction fetch bus between a fetch master and a memory responder.
interface ibex_instr_bus;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [6:0]  rdata_intg;
    logic        err;

    modport master (output req, addr, input gnt, rvalid, rdata, rdata_intg, err);
    modport slave  (input req, addr, output gnt, rvalid, rdata, rdata_intg, err);
endinterface

// File: rtl/instr_intg_encoder.sv
// Inverted SECDED(39,32) check-bit generator for fetch data integrity.
module instr_intg_encoder (
    input  logic [31:0] data,
    output logic [6:0]  intg
);
    logic [6:0] chk;

    assign chk[0] = ^(data & 32'h2606_BD25);
    assign chk[1] = ^(data & 32'hDEBA_8050);
    assign chk[2] = ^(data & 32'h413D_89AA);
    assign chk[3] = ^(data & 32'h3123_4ED1);
    assign chk[4] = ^(data & 32'hC2C1_323B);
    assign chk[5] = ^(data & 32'h2DCC_624C);
    assign chk[6] = ^(data & 32'h9850_5586);

    // Inversion keeps an all-zero word from carrying all-zero check bits.
    assign intg = chk ^ 7'h2A;
endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-bus responder fronting a synchronous single-port instruction SRAM.
// Optional integrity bits on rdata_intg: define INSTR_MEM_RESPONDER_INTG_EN.
module instr_mem_responder
    import memory_map::*;
#(
    parameter logic [31:0] BASE_ADDRESS = CODE_RAM_BASE_ADDRESS,
    parameter logic [31:0] SIZE_BYTES   = CODE_RAM_SIZE_BYTES,
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned AW           = $clog2(SIZE_BYTES) - 2
) (
    input  logic          clk,
    input  logic          rst,
    ibex_instr_bus.slave  instr_bus,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata
);
    localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    instr_resp_state_t state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, mem_addr_q, word, issue_addr;
    logic              hit_q, hit, gnt, rvalid, issue;
    logic [31:0]       offset, rdata;

    // Addresses below the base wrap to a large offset and fall out of range.
    assign offset = instr_bus.addr - BASE_ADDRESS;
    assign hit    = offset < SIZE_BYTES;
    assign word   = offset[AW+1:2];

    assign gnt    = instr_bus.req && !rst && (state_q == IDLE || state_q == RESPOND);
    assign rvalid = (state_q == RESPOND) && !rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESPOND: begin
                state_d = IDLE;
                if (gnt) begin
                    state_d = (WAIT_STATES > 0) ? WAIT : RESPOND;
                    cnt_d   = CW'(WAIT_STATES);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = RESPOND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            hit_q      <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr;
            if (gnt) begin
                addr_q <= word;
                hit_q  <= hit;
            end
        end
    end

    // The SRAM read lands in the cycle before RESPOND so data arrives with rvalid.
    assign issue      = (WAIT_STATES == 0) ? (gnt && hit)
                                           : (state_q == WAIT && cnt_q == CW'(1) && hit_q);
    assign issue_addr = (state_q == WAIT) ? addr_q : word;
    assign mem_req    = issue && !rst;
    assign mem_addr   = mem_req ? issue_addr : mem_addr_q;

    assign rdata = (rvalid && hit_q) ? mem_rdata : 32'h0;

    assign instr_bus.gnt    = gnt;
    assign instr_bus.rvalid = rvalid;
    assign instr_bus.rdata  = rdata;
    assign instr_bus.err    = rvalid && !hit_q;

`ifdef INSTR_MEM_RESPONDER_INTG_EN
    logic [6:0] enc_intg;

    instr_intg_encoder u_intg (
        .data (rdata),
        .intg (enc_intg)
    );

    assign instr_bus.rdata_intg = rvalid ? enc_intg : 7'b0;
`else
    assign instr_bus.rdata_intg = 7'b0;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: three instances (0, 3 and 2 wait states) checked by a scoreboard.
module tb_instr_mem_responder;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] SIZE = 32'h0000_1000;
    localparam int          NI   = 3;

    typedef struct {
        int          gcyc;
        logic        hit;
        logic [9:0]  word;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI-1:0]     req, gnt, rvalid, err, mreq;
    logic [31:0]       addr  [NI];
    logic [31:0]       rdata [NI];
    logic [6:0]        intg  [NI];
    logic [9:0]        maddr [NI];
    logic [31:0]       mrdata[NI];
    logic [31:0]       mem_img[1024];

    int   total = 0, bad = 0, cyc = 0;
    int   rv_cnt[NI];
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 3 : 2);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ibex_instr_bus bus ();
        assign bus.req   = req[g];
        assign bus.addr  = addr[g];
        assign gnt[g]    = bus.gnt;
        assign rvalid[g] = bus.rvalid;
        assign rdata[g]  = bus.rdata;
        assign intg[g]   = bus.rdata_intg;
        assign err[g]    = bus.err;

        instr_mem_responder #(
            .BASE_ADDRESS (BASE),
            .SIZE_BYTES   (SIZE),
            .WAIT_STATES  ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .instr_bus (bus),
            .mem_req   (mreq[g]),
            .mem_addr  (maddr[g]),
            .mem_rdata (mrdata[g])
        );

        always @(posedge clk) if (mreq[g]) mrdata[g] <= mem_img[maddr[g]];
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

`ifdef INSTR_MEM_RESPONDER_INTG_EN
    function automatic logic [6:0] ref_intg(input logic [31:0] d);
        logic [38:0] c;
        c = {7'b0, d};
        c[32] = ^(c & 39'h00_2606_BD25);
        c[33] = ^(c & 39'h00_DEBA_8050);
        c[34] = ^(c & 39'h00_413D_89AA);
        c[35] = ^(c & 39'h00_3123_4ED1);
        c[36] = ^(c & 39'h00_C2C1_323B);
        c[37] = ^(c & 39'h00_2DCC_624C);
        c[38] = ^(c & 39'h00_9850_5586);
        c ^= 39'h2A_0000_0000;
        return c[38:32];
    endfunction
`endif

    // Scoreboard: expectation pushed on grant, checked on mem_req, popped on rvalid.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (gnt[i]) begin
                exp_t        e;
                logic [31:0] off;
                off    = addr[i] - BASE;
                e.gcyc = cyc;
                e.hit  = (addr[i] >= BASE) && (off < SIZE);
                e.word = off[11:2];
                e.data = e.hit ? mem_img[e.word] : 32'h0;
                sb.push_back(e);
            end
            if (mreq[i]) begin
                chk("mreq_has_exp", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    chk("mreq_hit", 64'd1, 64'(sb[$].hit));
                    chk("mreq_cyc", 64'(cyc), 64'(sb[$].gcyc + ws_of(i)));
                    chk("mreq_addr", 64'(maddr[i]), 64'(sb[$].word));
                end
            end
            if (rvalid[i]) begin
                rv_cnt[i]++;
                chk("rv_has_exp", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rv_cyc", 64'(cyc), 64'(e.gcyc + 1 + ws_of(i)));
                    chk("rdata", 64'(rdata[i]), 64'(e.data));
                    chk("err", 64'(err[i]), 64'(!e.hit));
`ifdef INSTR_MEM_RESPONDER_INTG_EN
                    chk("intg", 64'(intg[i]), 64'(ref_intg(e.data)));
`else
                    chk("intg_off", 64'(intg[i]), 64'd0);
`endif
                end
            end else begin
                chk("idle_out", 64'({rdata[i], err[i], intg[i]}), 64'd0);
            end
        end
    end

    // Hold req until each address is granted; n addresses back to back.
    task automatic burst(input int i, input int n, input logic [31:0] a0, a1, a2);
        logic [31:0] al[3];
        int          gc[3];
        int          w;
        al = '{a0, a1, a2};
        req[i] = 1'b1;
        for (int k = 0; k < n; k++) begin
            addr[i] = al[k];
            w = 0;
            @(negedge clk);
            while (!gnt[i] && w < 40) begin
                @(negedge clk);
                w++;
            end
            chk("gnt_timeout", 64'(w < 40), 64'd1);
            gc[k] = cyc;
            if (k == 0) chk("gnt_first", 64'(w), 64'd0);
            else        chk("gnt_gap", 64'(gc[k] - gc[k-1]), 64'(ws_of(i) + 1));
            @(posedge clk);
            #1;
        end
        req[i] = 1'b0;
        repeat (ws_of(i) + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int k = 0; k < 1024; k++) mem_img[k] = 32'h5A00_0000 ^ (k * 32'h0001_0203);
        mem_img[1]     = 32'hDEAD_BEEF;
        mem_img[10'h3FF] = 32'hCAFE_F00D;
        for (int i = 0; i < NI; i++) begin
            addr[i]   = 32'h0;
            rv_cnt[i] = 0;
        end
        req = '0;
        rst = 1'b1;
        req[0] = 1'b1;
        addr[0] = BASE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_gnt", 64'(gnt[i]), 64'd0);
            chk("rst_mreq", 64'(mreq[i]), 64'd0);
            chk("rst_maddr", 64'(maddr[i]), 64'd0);
            chk("rst_rvalid", 64'(rvalid[i]), 64'd0);
        end
        req[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        burst(0, 1, 32'h0001_0004, 32'h0, 32'h0);
        burst(1, 1, 32'h0001_0FFC, 32'h0, 32'h0);
        burst(0, 1, 32'h0002_0000, 32'h0, 32'h0);
        burst(1, 1, 32'h0000_FFFC, 32'h0, 32'h0);
        burst(0, 3, 32'h0001_0000, 32'h0001_0004, 32'h0001_000A);
        burst(1, 2, 32'h0001_1000, 32'h0001_0008, 32'h0);

        // Reset in the last wait cycle of a two-wait-state fetch.
        req[2] = 1'b1;
        addr[2] = 32'h0001_0010;
        @(negedge clk);
        chk("rt_gnt", 64'(gnt[2]), 64'd1);
        n = cyc;
        @(posedge clk);
        #1 req[2] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rt_cyc", 64'(cyc), 64'(n + 2));
        chk("rt_mreq", 64'(mreq[2]), 64'd0);
        chk("rt_rvalid", 64'(rvalid[2]), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        req[2] = 1'b1;
        addr[2] = 32'h0001_0014;
        @(negedge clk);
        chk("rt_rvalid_after", 64'(rvalid[2]), 64'd0);
        chk("rt_gnt_after", 64'(gnt[2]), 64'd1);
        @(posedge clk);
        #1 req[2] = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("rv_cnt0", 64'(rv_cnt[0]), 64'd5);
        chk("rv_cnt1", 64'(rv_cnt[1]), 64'd4);
        chk("rv_cnt2", 64'(rv_cnt[2]), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
